debounce_gpio_event: RTL and testbench



---
 rtl/debounce_gpio_chan.sv | 120 ++++++++++++
 rtl/debounce_gpio_event.sv | 67 ++++++
 tb/tb_debounce_gpio_event.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_gpio_chan.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_gpio_chan
//  Description : One GPIO channel. Two-flop synchroniser, optional inversion,
//                N-sample history filter, rise/fall event pulses and a
//                long-press pulse timed in shared sample ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_gpio_chan #(
   parameter int   N                = 4,
   parameter int   LONG_PRESS_TICKS = 1000,
   parameter logic INVERT_BIT       = 1'b0,
   parameter logic INIT_BIT         = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_press
);

   localparam int              CNT_W   = $clog2(LONG_PRESS_TICKS + 1);
   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(LONG_PRESS_TICKS);
   localparam logic [CNT_W-1:0] LP_PRE = CNT_W'(LONG_PRESS_TICKS - 1);
   // Synchroniser reset value chosen so that the post-inversion sample
   // starts equal to the initial level.
   localparam logic             SYNC_INIT = INIT_BIT ^ INVERT_BIT;

   logic             sync_1;
   logic             sync_2;
   logic             s;
   logic [N-1:0]     hist;
   logic [N-1:0]     hist_next;
   logic             level_next;
   logic             level_d;
   logic [CNT_W-1:0] hold_cnt;

   // Two-flop synchroniser for the asynchronous pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= SYNC_INIT;
         sync_2 <= SYNC_INIT;
      end else begin
         sync_1 <= din;
         sync_2 <= sync_1;
      end
   end

   assign s = sync_2 ^ INVERT_BIT;

   generate
      if (N == 1) begin : g_hist_single
         assign hist_next = s;
      end else begin : g_hist_shift
         assign hist_next = {hist[N-2:0], s};
      end
   endgenerate

   // Next debounced level: unanimous history changes it, mixed history holds
   always_comb begin
      level_next = level;
      if (tick) begin
         if (&hist_next) begin
            level_next = 1'b1;
         end else if (~|hist_next) begin
            level_next = 1'b0;
         end
      end
   end

   // Sample history and debounced level, both advanced on the shared tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist  <= {N{INIT_BIT}};
         level <= INIT_BIT;
      end else begin
         if (tick) begin
            hist <= hist_next;
         end
         level <= level_next;
      end
   end

   // Edge detection against a one-cycle-delayed copy of the level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d <= INIT_BIT;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         level_d <= level;
         rise    <= level & ~level_d;
         fall    <= ~level & level_d;
      end
   end

   // Long-press timer: counts ticks while the level stays high; a falling
   // level on the same tick clears it before any pulse can be issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt   <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= 1'b0;
         if (!level_next) begin
            hold_cnt <= '0;
         end else if (tick && level && (hold_cnt != LP_MAX)) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
            if (hold_cnt == LP_PRE) begin
               long_press <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/debounce_gpio_event.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_gpio_event
//  Description : WIDTH-channel GPIO debouncer. Shared sample-rate prescaler
//                plus one debounce_gpio_chan per input channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_gpio_event #(
   parameter int               WIDTH            = 9,
   parameter int               N                = 4,
   parameter int               RATE             = 250000,
   parameter int               LONG_PRESS_TICKS = 1000,
   parameter logic [WIDTH-1:0] INVERT           = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] INIT_VALUE       = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] long_press,
   output logic             sample_tick
);

   localparam int              PRE_W    = (RATE > 1) ? $clog2(RATE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RATE - 1);

   logic [PRE_W-1:0] pre_cnt;

   // Prescaler: wraps every RATE cycles; tick is registered off the last count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt     <= '0;
         sample_tick <= 1'b0;
      end else begin
         sample_tick <= (pre_cnt == PRE_LAST);
         if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
      end
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_chan
         debounce_gpio_chan #(
            .N                (N),
            .LONG_PRESS_TICKS (LONG_PRESS_TICKS),
            .INVERT_BIT       (INVERT[i]),
            .INIT_BIT         (INIT_VALUE[i])
         ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (sample_tick),
            .din        (in[i]),
            .level      (out[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_gpio_event.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_gpio_event
//  Description : Directed self-checking bench for debounce_gpio_event
//                (WIDTH=2, N=4, RATE=4, LONG_PRESS_TICKS=8,
//                INVERT=2'b10, INIT_VALUE=2'b10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_gpio_event;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] din;
   logic [1:0] dout;
   logic [1:0] rise;
   logic [1:0] fall;
   logic [1:0] lp;
   logic       st;

   int tests = 0;
   int fails = 0;

   // Event monitor state (written only by the monitor process)
   int         tick_cnt = 0;
   int         rise_cnt [2] = '{0, 0};
   int         fall_cnt [2] = '{0, 0};
   int         lp_cnt   [2] = '{0, 0};
   int         rise_tick[2] = '{0, 0};
   int         lp_tick  [2] = '{0, 0};
   int         both_cnt    = 0;
   int         width_err   = 0;
   int         overlap_err = 0;
   logic [1:0] rise_q = '0;
   logic [1:0] fall_q = '0;
   logic [1:0] lp_q   = '0;

   debounce_gpio_event #(
      .WIDTH            (2),
      .N                (4),
      .RATE             (4),
      .LONG_PRESS_TICKS (8),
      .INVERT           (2'b10),
      .INIT_VALUE       (2'b10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in          (din),
      .out         (dout),
      .rise        (rise),
      .fall        (fall),
      .long_press  (lp),
      .sample_tick (st)
   );

   always #5 clk = ~clk;

   // Count pulses and tick positions on the falling edge
   always @(negedge clk) begin
      if (st === 1'b1) tick_cnt <= tick_cnt + 1;
      for (int c = 0; c < 2; c++) begin
         if (rise[c] === 1'b1) begin
            rise_cnt[c]  <= rise_cnt[c] + 1;
            rise_tick[c] <= tick_cnt;
         end
         if (fall[c] === 1'b1) fall_cnt[c] <= fall_cnt[c] + 1;
         if (lp[c] === 1'b1) begin
            lp_cnt[c]  <= lp_cnt[c] + 1;
            lp_tick[c] <= tick_cnt;
         end
      end
      if ((rise[0] === 1'b1) && (fall[1] === 1'b1)) both_cnt <= both_cnt + 1;
      if (((rise & rise_q) | (fall & fall_q) | (lp & lp_q)) != 2'b00)
         width_err <= width_err + 1;
      if ((rise & fall) != 2'b00) overlap_err <= overlap_err + 1;
      rise_q <= rise;
      fall_q <= fall;
      lp_q   <= lp;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hard stop in case a wait loop is ever bypassed
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      int         base_a;
      int         base_b;
      int         base_c;
      int         inter;
      logic [7:0] pat;

      // ---------------- 1. reset ----------------
      rst_n = 1'b0;
      din   = 2'b00;
      repeat (3) step();
      check("t1_rst_out", dout, 2'b10);
      check("t1_rst_rise", rise, 2'b00);
      check("t1_rst_fall", fall, 2'b00);
      check("t1_rst_lp", lp, 2'b00);
      check("t1_rst_tick", st, 1'b0);
      base_a = rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1];
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (st === 1'b1) begin
            n = i;
            break;
         end
      end
      check("t1_first_tick", n, 4);
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         pat[i] = st;
      end
      check("t1_tick_period", pat, 8'b1000_1000);
      check("t1_no_events", rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1] - base_a, 0);
      check("t1_out_held", dout, 2'b10);

      // ---------------- 3. glitch rejection (3 ticks high) ----------------
      base_a = rise_cnt[0];
      base_b = fall_cnt[0];
      din[0] = 1'b1;
      repeat (12) step();
      din[0] = 1'b0;
      repeat (30) step();
      check("t3_glitch_out", dout, 2'b10);
      check("t3_glitch_rise", rise_cnt[0] - base_a, 0);
      check("t3_glitch_fall", fall_cnt[0] - base_b, 0);

      // ---------------- 2. clean press ----------------
      base_a = rise_cnt[0];
      base_b = fall_cnt[0];
      base_c = lp_cnt[0];
      din[0] = 1'b1;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (dout[0] === 1'b1) begin
            n = i;
            break;
         end
      end
      check("t2_latency_in_window", ((n >= 15) && (n <= 22)) ? 1 : 0, 1);
      check("t2_rise_not_yet", rise[0], 1'b0);
      step();
      check("t2_rise_pulse", rise[0], 1'b1);
      step();
      check("t2_rise_ends", rise[0], 1'b0);
      check("t2_rise_count", rise_cnt[0] - base_a, 1);
      check("t2_no_fall", fall_cnt[0] - base_b, 0);

      // ---------------- 4. long press ----------------
      for (int i = 0; i < 60; i++) begin
         if (lp_cnt[0] != base_c) break;
         step();
      end
      check("t4_lp_once", lp_cnt[0] - base_c, 1);
      check("t4_lp_delay_ticks", lp_tick[0] - rise_tick[0], 8);
      repeat (80) step();
      check("t4_no_repulse", lp_cnt[0] - base_c, 1);
      check("t4_out_still_high", dout[0], 1'b1);
      base_b = fall_cnt[0];
      din[0] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (dout[0] === 1'b0) break;
         step();
      end
      repeat (3) step();
      check("t4_release_fall", fall_cnt[0] - base_b, 1);
      base_a = rise_cnt[0];
      base_c = lp_cnt[0];
      din[0] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (lp_cnt[0] != base_c) break;
         step();
      end
      check("t4_repress_rise", rise_cnt[0] - base_a, 1);
      check("t4_repress_lp", lp_cnt[0] - base_c, 1);
      check("t4_repress_delay", lp_tick[0] - rise_tick[0], 8);

      // ---------------- 5. inversion and parallelism ----------------
      din = 2'b00;
      for (int i = 0; i < 40; i++) begin
         if (dout === 2'b10) break;
         step();
      end
      repeat (3) step();
      check("t5_start_out", dout, 2'b10);
      base_a = both_cnt;
      // Channel 1 is active-low, so driving its pin high releases it.
      din   = 2'b11;
      inter = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (dout === 2'b01) break;
         if (dout !== 2'b10) inter = 1;
      end
      check("t5_out_swapped", dout, 2'b01);
      check("t5_no_intermediate", inter, 0);
      repeat (3) step();
      check("t5_same_cycle_events", both_cnt - base_a, 1);

      // ---------------- 6. async reset mid-operation ----------------
      base_a = tick_cnt;
      for (int i = 0; i < 40; i++) begin
         if (tick_cnt - base_a >= 5) break;
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_out", dout, 2'b10);
      check("t6_async_pulses", {rise, fall, lp}, 6'b0);
      check("t6_async_tick", st, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      base_c = lp_cnt[0];
      n = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (dout[0] === 1'b1) begin
            n = i;
            break;
         end
      end
      check("t6_redebounce_cycles", n, 17);
      check("t6_redebounce_out", dout, 2'b01);
      for (int i = 0; i < 60; i++) begin
         if (lp_cnt[0] != base_c) break;
         step();
      end
      check("t6_fresh_lp", lp_cnt[0] - base_c, 1);
      check("t6_fresh_lp_delay", lp_tick[0] - rise_tick[0], 8);

      // ---------------- global pulse properties ----------------
      check("pulse_width_one_cycle", width_err, 0);
      check("rise_fall_exclusive", overlap_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
